// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches one RV32I OP/OP-IMM word at a time,
// drives an external ALU and writes the result back to x1..x31.
module alu_sequencer #(
  parameter int CLEAR_REGS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_func3,
  output logic        alu_opequal,
  input  logic [31:0] alu_out,
  output logic        done,
  output logic        illegal,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEC,
    S_EXE,
    S_WB,
    S_ILL
  } state_t;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  state_t      r_state;
  logic [31:0] r_instr;
  logic [31:0] r_result;
  logic [31:0] r_alu_in1;
  logic [31:0] r_alu_in2;
  logic [2:0]  r_alu_func3;
  logic        r_alu_opequal;
  logic        r_done;
  logic        r_illegal;
  logic [31:0] r_rf [32];

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_is_op;
  logic        w_is_imm;
  logic        w_op_ok;
  logic        w_imm_ok;
  logic        w_legal;
  logic        w_opeq;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm;
  logic [31:0] w_op2;

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_f3     = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_f7     = r_instr[31:25];
  assign w_imm    = {{20{r_instr[31]}}, r_instr[31:20]};

  assign w_is_op  = (w_opcode == OPC_OP);
  assign w_is_imm = (w_opcode == OPC_IMM);

  // Register file reads; x0 is hardwired to zero
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : r_rf[dbg_raddr];

  // OP: base ops with funct7=0, only ADD/SRL get the SUB/SRA variant
  always_comb begin
    w_op_ok = 1'b0;
    unique case (1'b1)
      (w_f7 == F7_ZERO): w_op_ok = 1'b1;
      (w_f7 == F7_ALT):  w_op_ok = (w_f3 == 3'b000) ||
                                   (w_f3 == 3'b101);
      default:           w_op_ok = 1'b0;
    endcase
  end

  // OP-IMM: only shifts constrain the upper immediate bits
  always_comb begin
    w_imm_ok = 1'b1;
    case (w_f3)
      3'b001:  w_imm_ok = (w_f7 == F7_ZERO);
      3'b101:  w_imm_ok = (w_f7 == F7_ZERO) ||
                          (w_f7 == F7_ALT);
      default: w_imm_ok = 1'b1;
    endcase
  end

  assign w_legal = (w_is_op && w_op_ok) ||
                   (w_is_imm && w_imm_ok);

  // Bit 30 selects SUB/SRA, but for OP-IMM only SRAI uses it
  assign w_opeq = w_is_op ? r_instr[30] :
                  (w_f3 == 3'b101) ? r_instr[30] : 1'b0;

  assign w_op2 = w_is_op ? w_rs2_val : w_imm;

  // Sequencer FSM with registered ALU operands and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_instr       <= 32'd0;
      r_result      <= 32'd0;
      r_alu_in1     <= 32'd0;
      r_alu_in2     <= 32'd0;
      r_alu_func3   <= 3'd0;
      r_alu_opequal <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= S_DEC;
          end
        end
        S_DEC: begin
          if (w_legal) begin
            r_alu_in1     <= w_rs1_val;
            r_alu_in2     <= w_op2;
            r_alu_func3   <= w_f3;
            r_alu_opequal <= w_opeq;
            r_state       <= S_EXE;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= S_ILL;
          end
        end
        S_EXE: begin
          r_result <= alu_out;
          r_done   <= 1'b1;
          r_state  <= S_WB;
        end
        S_WB:    r_state <= S_IDLE;
        S_ILL:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Writeback at the end of WB; reset optionally wipes the file
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_REGS != 0) begin
        for (int i = 0; i < 32; i++) begin
          r_rf[i] <= 32'd0;
        end
      end
    end else if (r_state == S_WB && w_rd != 5'd0) begin
      r_rf[w_rd] <= r_result;
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign alu_in1     = r_alu_in1;
  assign alu_in2     = r_alu_in2;
  assign alu_func3   = r_alu_func3;
  assign alu_opequal = r_alu_opequal;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign rd_addr     = r_done ? w_rd : 5'd0;
  assign rd_data     = r_done ? r_result : 32'd0;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors with hand-computed results;
// a behavioural RV32I ALU closes the loop on alu_* / alu_out.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'd0;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [2:0]  alu_func3;
  logic        alu_opequal;
  logic [31:0] alu_out;
  logic        done;
  logic        illegal;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  dbg_raddr = 5'd0;
  logic [31:0] dbg_rdata;

  int n_chk = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int both_cnt = 0;
  logic [31:0] exp_rf [32];

  always #5 clk = ~clk;

  alu_sequencer #(.CLEAR_REGS(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_func3   (alu_func3),
    .alu_opequal (alu_opequal),
    .alu_out     (alu_out),
    .done        (done),
    .illegal     (illegal),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata)
  );

  always_comb begin
    alu_out = 32'd0;
    case (alu_func3)
      3'b000: alu_out = alu_opequal ? alu_in1 - alu_in2
                                    : alu_in1 + alu_in2;
      3'b001: alu_out = alu_in1 << alu_in2[4:0];
      3'b010: alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
      3'b011: alu_out = {31'd0, alu_in1 < alu_in2};
      3'b100: alu_out = alu_in1 ^ alu_in2;
      3'b101: alu_out = alu_opequal
                      ? $unsigned($signed(alu_in1) >>> alu_in2[4:0])
                      : alu_in1 >> alu_in2[4:0];
      3'b110: alu_out = alu_in1 | alu_in2;
      default: alu_out = alu_in1 & alu_in2;
    endcase
  end

  always @(posedge clk) begin
    if (instr_valid && instr_ready) acc_cnt++;
    if (done) done_cnt++;
    if (done && illegal) both_cnt++;
  end

  task automatic wait_ready(input string nm);
    int k = 0;
    while (!instr_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (instr_ready !== 1'b1) begin
      $display("FAIL %s ready_timeout got=%b want=1", nm, instr_ready);
      n_fail++;
    end
  endtask

  task automatic issue(input logic [31:0] w, input string nm);
    @(negedge clk);
    wait_ready(nm);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic check_all_regs(input string nm);
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = 5'(i);
      #1;
      n_chk++;
      if (dbg_rdata !== exp_rf[i]) begin
        $display("FAIL %s x%0d got=%h want=%h",
                 nm, i, dbg_rdata, exp_rf[i]);
        n_fail++;
      end
    end
  endtask

  task automatic exec_chk(input logic [31:0] w,
                          input logic [2:0] f3,
                          input logic oe,
                          input logic [4:0] rd,
                          input logic [31:0] data,
                          input string nm);
    issue(w, nm);
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || illegal !== 1'b0 || instr_ready !== 1'b0) begin
      $display("FAIL %s c1 done=%b ill=%b rdy=%b want 0/0/0",
               nm, done, illegal, instr_ready);
      n_fail++;
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || illegal !== 1'b0 ||
        alu_func3 !== f3 || alu_opequal !== oe) begin
      $display("FAIL %s c2 done=%b ill=%b f3=%b oe=%b want 0/0/%b/%b",
               nm, done, illegal, alu_func3, alu_opequal, f3, oe);
      n_fail++;
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || illegal !== 1'b0 ||
        rd_addr !== rd || rd_data !== data) begin
      $display("FAIL %s c3 done=%b ill=%b rd=%0d data=%h want 1/0/%0d/%h",
               nm, done, illegal, rd_addr, rd_data, rd, data);
      n_fail++;
    end
    if (rd != 5'd0) exp_rf[rd] = data;
    @(negedge clk);
    dbg_raddr = rd;
    #1;
    n_chk++;
    if (dbg_rdata !== exp_rf[rd]) begin
      $display("FAIL %s dbg x%0d got=%h want=%h",
               nm, rd, dbg_rdata, exp_rf[rd]);
      n_fail++;
    end
    n_chk++;
    if (done !== 1'b0 || rd_addr !== 5'd0 ||
        rd_data !== 32'd0 || instr_ready !== 1'b1) begin
      $display("FAIL %s c4 done=%b rd=%0d data=%h rdy=%b want 0/0/0/1",
               nm, done, rd_addr, rd_data, instr_ready);
      n_fail++;
    end
  endtask

  task automatic ill_chk(input logic [31:0] w,
                         input logic [31:0] in2,
                         input logic [2:0] f3,
                         input string nm);
    issue(w, nm);
    @(negedge clk);
    n_chk++;
    if (illegal !== 1'b0 || done !== 1'b0) begin
      $display("FAIL %s c1 ill=%b done=%b want 0/0", nm, illegal, done);
      n_fail++;
    end
    @(negedge clk);
    n_chk++;
    if (illegal !== 1'b1 || done !== 1'b0 ||
        alu_in2 !== in2 || alu_func3 !== f3) begin
      $display("FAIL %s c2 ill=%b done=%b in2=%h f3=%b want 1/0/%h/%b",
               nm, illegal, done, alu_in2, alu_func3, in2, f3);
      n_fail++;
    end
    @(negedge clk);
    n_chk++;
    if (illegal !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b1) begin
      $display("FAIL %s c3 ill=%b done=%b rdy=%b want 0/0/1",
               nm, illegal, done, instr_ready);
      n_fail++;
    end
    check_all_regs(nm);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
    n_chk++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0 ||
        rd_addr !== 5'd0 || rd_data !== 32'd0) begin
      $display("FAIL reset ctl rdy=%b done=%b ill=%b rd=%0d data=%h",
               instr_ready, done, illegal, rd_addr, rd_data);
      n_fail++;
    end
    n_chk++;
    if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 ||
        alu_func3 !== 3'd0 || alu_opequal !== 1'b0) begin
      $display("FAIL reset alu in1=%h in2=%h f3=%b oe=%b want zeros",
               alu_in1, alu_in2, alu_func3, alu_opequal);
      n_fail++;
    end
    check_all_regs("reset_rf");
  endtask

  task automatic test_addi();
    exec_chk(32'h00500093, 3'b000, 1'b0, 5'd1, 32'd5, "addi_x1");
  endtask

  task automatic test_back_to_back();
    exec_chk(32'hFFD00113, 3'b000, 1'b0, 5'd2, 32'hFFFFFFFD, "addi_x2");
    exec_chk(32'h402081B3, 3'b000, 1'b1, 5'd3, 32'h00000008, "sub_x3");
  endtask

  task automatic test_srai();
    exec_chk(32'h40115213, 3'b101, 1'b1, 5'd4, 32'hFFFFFFFE, "srai_x4");
  endtask

  task automatic test_x0_dest();
    exec_chk(32'h00700013, 3'b000, 1'b0, 5'd0, 32'd7, "addi_x0");
  endtask

  task automatic test_op_misc();
    exec_chk(32'h0020C333, 3'b100, 1'b0, 5'd6, 32'hFFFFFFF8, "xor_x6");
    exec_chk(32'h002103B3, 3'b000, 1'b0, 5'd7, 32'hFFFFFFFA, "add_wrap");
  endtask

  task automatic test_illegal();
    ill_chk(32'h00000073, 32'hFFFFFFFD, 3'b000, "ill_system");
    ill_chk(32'h02208233, 32'hFFFFFFFD, 3'b000, "ill_mul");
    ill_chk(32'h40109093, 32'hFFFFFFFD, 3'b000, "ill_slli_f7");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wait_ready("rst_mid");
    done_cnt = 0;
    instr = 32'h00900293;
    instr_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
    dbg_raddr = 5'd5;
    #1;
    n_chk++;
    if (done !== 1'b0 || illegal !== 1'b0 ||
        instr_ready !== 1'b1 || dbg_rdata !== 32'd0) begin
      $display("FAIL rst_mid post done=%b ill=%b rdy=%b x5=%h want 0/0/1/0",
               done, illegal, instr_ready, dbg_rdata);
      n_fail++;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++;
    if (acc_cnt !== 1) begin
      $display("FAIL rst_mid accepts got=%0d want=1", acc_cnt);
      n_fail++;
    end
    n_chk++;
    if (done_cnt !== 1) begin
      $display("FAIL rst_mid done_pulses got=%0d want=1", done_cnt);
      n_fail++;
    end
    exp_rf[5] = 32'd9;
    check_all_regs("rst_mid_rf");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_srai();
    test_x0_dest();
    test_op_misc();
    test_illegal();
    test_reset_mid();
    n_chk++;
    if (both_cnt !== 0) begin
      $display("FAIL done_and_illegal got=%0d want=0", both_cnt);
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
